execute_divider: RTL

Multi-cycle integer divider for the execute stage, serving the UDIV/SDIV opcodes. It takes the two register operands produced by iDecode (read_data1 / read_data2) and returns a quotient for iWriteBack. It uses a start/done handshake. A restoring shift-subtract engine retires one quotient bit per cycle.

---
 rtl/execute_divider_pkg.sv | 28 ++
 rtl/execute_divider_div_step.sv | 29 ++
 rtl/execute_divider.sv | 126 ++++++++++++
 3 files changed

// File: rtl/execute_divider_pkg.sv
// Shared definitions for the execute-stage divider: word sizes, FSM states,
// counter sizing and the LEGv8 divide opcode encodings used by decode/execute.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package execute_divider_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  localparam int DIV_WIDTH = `WORD;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  // UDIV and SDIV share the R-format opcode; the shamt field selects the flavour.
  localparam logic [10:0] OPC_DIV    = 11'b10011010110;
  localparam logic [5:0]  SHAMT_SDIV = 6'b000010;
  localparam logic [5:0]  SHAMT_UDIV = 6'b000011;

endpackage

// File: rtl/execute_divider_div_step.sv
// One restoring shift-subtract iteration: shifts {rem, dvd} left and retires
// one quotient bit into the LSB of dvd.
import execute_divider_pkg::*;

module div_step #(
  parameter int WIDTH = `WORD
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // The shifted remainder can exceed WIDTH bits, but after a successful
    // subtract it is always below dvs, so the low WIDTH bits of the difference suffice.
    rem_sh = {rem_i, dvd_i[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_i});
    diff   = rem_sh[WIDTH-1:0] - dvs_i;
    rem_o  = ge ? diff : rem_sh[WIDTH-1:0];
    dvd_o  = {dvd_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/execute_divider.sv
// Multi-cycle UDIV/SDIV unit: start/done handshake around a one-bit-per-cycle
// restoring divider, with sign fix-up and LEGv8 divide-by-zero results.
import execute_divider_pkg::*;

module execute_divider #(
  parameter int WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem, step_dvd;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      quot_q   <= '0;
      remo_q   <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      quot_q   <= quot_d;
      remo_q   <= remo_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    quot_d   = quot_q;
    remo_d   = remo_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '0;
            remo_d  = dividend;
            dbz_d   = 1'b1;
          end else begin
            // Sign latches are pre-gated so FIX needs no knowledge of is_signed.
            // |MIN| stays 2^(WIDTH-1) as an unsigned magnitude.
            sign_a_d = is_signed & dividend[WIDTH-1];
            sign_b_d = is_signed & divisor[WIDTH-1];
            dvd_d    = sign_a_d ? ('0 - dividend) : dividend;
            dvs_d    = sign_b_d ? ('0 - divisor) : divisor;
            rem_d    = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = (sign_a_q ^ sign_b_q) ? ('0 - dvd_q) : dvd_q;
        remo_d  = sign_a_q ? ('0 - rem_q) : rem_q;
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
